// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared encodings for the whack-a-mole game engine
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_t;

  localparam logic [7:0] BREAK        = 8'hF0;
  localparam logic [7:0] DEF_KEY_MOVE = 8'h23;
  localparam logic [7:0] DEF_KEY_HIT  = 8'h29;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Galois LFSR, x^16+x^14+x^13+x^11
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (enable) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// rtl/whack_game_ctrl.sv - PS/2 key decoder and game FSM for the whack-a-mole core
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int          N_HOLES       = 4,
  parameter int          POS_W         = $clog2(N_HOLES),
  parameter int          SCORE_W       = 5,
  parameter int          TIME_W        = 5,
  parameter int          GAME_SECONDS  = 30,
  parameter int          TICKS_PER_SEC = 8,
  parameter int          MOLE_TICKS    = 12,
  parameter logic [7:0]  KEY_MOVE      = DEF_KEY_MOVE,
  parameter logic [7:0]  KEY_HIT       = DEF_KEY_HIT,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic               start,
  output logic [1:0]         state,
  output logic [POS_W-1:0]   cursor_pos,
  output logic [POS_W-1:0]   mole_pos,
  output logic               mole_up,
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  time_left,
  output logic               hit,
  output logic               miss
);

  localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int LIFE_W = $clog2(MOLE_TICKS + 1);

  game_state_t        state_q, state_d;
  logic [POS_W-1:0]   cursor_q, cursor_d, mole_q, mole_d;
  logic               up_q, up_d, hit_q, hit_d, miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic               brk_q, brk_d, mv_held_q, mv_held_d, ht_held_q, ht_held_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [LIFE_W-1:0]  life_q, life_d;

  logic               move_ev, whack_ev, good, time_out;
  logic [15:0]        lfsr_q;
  logic [POS_W+7:0]   prod;
  logic [POS_W-1:0]   idx, spawn;
  logic               unused_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .state  (lfsr_q)
  );

  // Scale the top LFSR byte onto 0..N_HOLES-1, then bump off the current hole
  assign prod  = {{POS_W{1'b0}}, lfsr_q[15:8]} * (POS_W+8)'(N_HOLES);
  assign idx   = prod[POS_W+7:8];
  assign spawn = (idx != mole_q) ? idx :
                 (idx == POS_W'(N_HOLES-1)) ? '0 : idx + 1'b1;
  assign unused_bits = ^{lfsr_q[7:0], prod[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cursor_q  <= '0;
      mole_q    <= '0;
      up_q      <= 1'b0;
      score_q   <= '0;
      time_q    <= TIME_W'(GAME_SECONDS);
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      brk_q     <= 1'b0;
      mv_held_q <= 1'b0;
      ht_held_q <= 1'b0;
      sec_q     <= '0;
      life_q    <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      mole_q    <= mole_d;
      up_q      <= up_d;
      score_q   <= score_d;
      time_q    <= time_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      brk_q     <= brk_d;
      mv_held_q <= mv_held_d;
      ht_held_q <= ht_held_d;
      sec_q     <= sec_d;
      life_q    <= life_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    mole_d    = mole_q;
    up_d      = up_q;
    score_d   = score_q;
    time_d    = time_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    brk_d     = brk_q;
    mv_held_d = mv_held_q;
    ht_held_d = ht_held_q;
    sec_d     = sec_q;
    life_d    = life_q;
    move_ev   = 1'b0;
    whack_ev  = 1'b0;
    good      = 1'b0;
    time_out  = 1'b0;

    // A byte following F0 only releases a key; it never acts as a make code
    if (key_valid) begin
      if (brk_q) begin
        brk_d = 1'b0;
        if (key_code == KEY_MOVE) mv_held_d = 1'b0;
        if (key_code == KEY_HIT)  ht_held_d = 1'b0;
      end else if (key_code == BREAK) begin
        brk_d = 1'b1;
      end else if (key_code == KEY_MOVE && !mv_held_q) begin
        move_ev   = 1'b1;
        mv_held_d = 1'b1;
      end else if (key_code == KEY_HIT && !ht_held_q) begin
        whack_ev  = 1'b1;
        ht_held_d = 1'b1;
      end
    end

    if (move_ev) begin
      cursor_d = (cursor_q == POS_W'(N_HOLES-1)) ? '0 : cursor_q + 1'b1;
    end

    case (state_q)
      ST_PLAY: begin
        good = whack_ev && up_q && (cursor_q == mole_q);
        if (whack_ev) begin
          if (good) begin
            hit_d = 1'b1;
            up_d  = 1'b0;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
          end else begin
            miss_d = 1'b1;
          end
        end
        if (tick) begin
          if (sec_q == SEC_W'(TICKS_PER_SEC-1)) begin
            sec_d    = '0;
            time_d   = time_q - 1'b1;
            time_out = (time_q == TIME_W'(1));
          end else begin
            sec_d = sec_q + 1'b1;
          end
          if (!good) begin
            if (!up_q) begin
              up_d   = 1'b1;
              mole_d = spawn;
              life_d = LIFE_W'(MOLE_TICKS);
            end else if (life_q == LIFE_W'(1)) begin
              miss_d = 1'b1;
              mole_d = spawn;
              life_d = LIFE_W'(MOLE_TICKS);
            end else begin
              life_d = life_q - 1'b1;
            end
          end
          if (time_out) begin
            state_d = ST_OVER;
            up_d    = 1'b0;
          end
        end
      end
      default: begin
        if (start || whack_ev) begin
          state_d = ST_PLAY;
          score_d = '0;
          time_d  = TIME_W'(GAME_SECONDS);
          sec_d   = '0;
          up_d    = 1'b1;
          mole_d  = spawn;
          life_d  = LIFE_W'(MOLE_TICKS);
        end
      end
    endcase
  end

  assign state      = state_q;
  assign cursor_pos = cursor_q;
  assign mole_pos   = mole_q;
  assign mole_up    = up_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign hit        = hit_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb/tb_whack_game_ctrl.sv - bench for whack_game_ctrl against a behavioural game model
module tb_whack_game_ctrl;

  localparam int N    = 4;
  localparam int TPS  = 8;
  localparam int MOLE = 12;
  localparam int GAME = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       start = 1'b0;
  logic [1:0] state;
  logic [1:0] cursor_pos, mole_pos;
  logic       mole_up, hit, miss;
  logic [4:0] score, time_left;

  always #5 clk = ~clk;

  whack_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start      (start),
    .state      (state),
    .cursor_pos (cursor_pos),
    .mole_pos   (mole_pos),
    .mole_up    (mole_up),
    .score      (score),
    .time_left  (time_left),
    .hit        (hit),
    .miss       (miss)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model: time is derived from total elapsed ticks, mole lifetime from its age
  int m_state, m_cursor, m_mole, m_up, m_score, m_hit, m_miss, elapsed, age;
  int brk, held_mv, held_ht, lf;

  always @(posedge clk or negedge reset) begin
    int pick, ev_mv, ev_wk, good, up_old, cur_old;
    if (!reset) begin
      m_state = 0; m_cursor = 0; m_mole = 0; m_up = 0; m_score = 0;
      m_hit = 0; m_miss = 0; elapsed = 0; age = 0;
      brk = 0; held_mv = 0; held_ht = 0; lf = 16'hACE1;
    end else begin
      pick = ((lf >> 8) * N) / 256;
      if (pick == m_mole) pick = (pick + 1) % N;
      lf = (lf >> 1) ^ (((lf & 1) != 0) ? 16'hB400 : 0);
      ev_mv = 0; ev_wk = 0; m_hit = 0; m_miss = 0;
      if (key_valid) begin
        if (brk != 0) begin
          brk = 0;
          if (key_code == 8'h23) held_mv = 0;
          if (key_code == 8'h29) held_ht = 0;
        end else if (key_code == 8'hF0) brk = 1;
        else if (key_code == 8'h23 && held_mv == 0) begin ev_mv = 1; held_mv = 1; end
        else if (key_code == 8'h29 && held_ht == 0) begin ev_wk = 1; held_ht = 1; end
      end
      cur_old = m_cursor;
      if (ev_mv != 0) m_cursor = (m_cursor + 1) % N;
      if (m_state != 1) begin
        if (start || ev_wk != 0) begin
          m_state = 1; m_score = 0; elapsed = 0; m_up = 1; age = 0; m_mole = pick;
        end
      end else begin
        up_old = m_up;
        good = (ev_wk != 0 && m_up != 0 && cur_old == m_mole) ? 1 : 0;
        if (ev_wk != 0) begin
          if (good != 0) begin
            m_hit = 1; m_up = 0;
            if (m_score < 31) m_score++;
          end else m_miss = 1;
        end
        if (tick) begin
          elapsed++;
          if (good == 0) begin
            if (up_old == 0) begin
              m_up = 1; m_mole = pick; age = 0;
            end else begin
              age++;
              if (age == MOLE) begin m_miss = 1; m_mole = pick; age = 0; end
            end
          end
          if (elapsed == GAME * TPS) begin m_state = 2; m_up = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("state", state, m_state);
    check("cursor_pos", cursor_pos, m_cursor);
    check("mole_pos", mole_pos, m_mole);
    check("mole_up", mole_up, m_up);
    check("score", score, m_score);
    check("time_left", time_left, GAME - elapsed / TPS);
    check("hit", hit, m_hit);
    check("miss", miss, m_miss);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send_key(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    cyc();
    key_valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic press(input logic [7:0] c);
    send_key(c);
    send_key(8'hF0);
    send_key(c);
  endtask

  task automatic steer();
    for (int i = 0; i < N && m_cursor != m_mole; i++) press(8'h23);
  endtask

  task automatic hit_one(output int h);
    if (m_up == 0) do_tick();
    steer();
    send_key(8'h29);
    h = hit;
    send_key(8'hF0);
    send_key(8'h29);
  endtask

  initial begin
    int old, h;
    int exp_cur[6] = '{1, 1, 1, 1, 1, 2};
    logic [7:0] seq[6] = '{8'h23, 8'h23, 8'h23, 8'hF0, 8'h23, 8'h23};

    repeat (2) @(posedge clk);
    #2;
    check("rst_state", state, 0);
    check("rst_time", time_left, 30);
    check("rst_cursor", cursor_pos, 0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) begin
      send_key(seq[i]);
      check($sformatf("cursor_seq%0d", i), cursor_pos, exp_cur[i]);
    end
    send_key(8'hF0);
    send_key(8'h23);

    start = 1'b1;
    cyc();
    start = 1'b0;
    check("start_state", state, 1);
    check("start_up", mole_up, 1);
    steer();
    send_key(8'h29);
    check("hit_pulse", hit, 1);
    check("hit_score", score, 1);
    check("hit_down", mole_up, 0);
    send_key(8'hF0);
    check("hit_one_cycle", hit, 0);
    send_key(8'h29);
    old = m_mole;
    do_tick();
    check("respawn_up", mole_up, 1);
    check("respawn_moved", (mole_pos != old) ? 1 : 0, 1);

    old = m_mole;
    repeat (11) do_tick();
    check("no_miss_11", miss, 0);
    do_tick();
    check("expire_miss", miss, 1);
    check("expire_moved", (mole_pos != old) ? 1 : 0, 1);

    steer();
    repeat (11) do_tick();
    key_valid = 1'b1; key_code = 8'h29; tick = 1'b1;
    cyc();
    key_valid = 1'b0; tick = 1'b0;
    check("sim_hit", hit, 1);
    check("sim_no_miss", miss, 0);
    send_key(8'hF0);
    send_key(8'h29);

    for (int i = 0; i < 10 && m_score < 7; i++) hit_one(h);
    check("pre_reset_score", score, 7);
    #1 reset = 1'b0;
    #1;
    check("async_state", state, 0);
    check("async_score", score, 0);
    check("async_time", time_left, 30);
    check("async_up", mole_up, 0);
    check("async_mole", mole_pos, 0);
    check("async_cursor", cursor_pos, 0);
    cyc();
    reset = 1'b1;
    cyc();
    check("post_rst_state", state, 0);
    check("post_rst_time", time_left, 30);

    press(8'h29);
    check("whack_start", state, 1);
    hit_one(h);
    check("game_score1", score, 1);
    for (int i = 0; i < 240; i++) begin
      do_tick();
      if (i == 7) check("time_29", time_left, 29);
      if (i == 238) check("still_play", state, 1);
    end
    check("over_state", state, 2);
    check("over_time", time_left, 0);
    check("over_up", mole_up, 0);
    repeat (10) do_tick();
    check("over_score_hold", score, 1);
    check("over_time_hold", time_left, 0);
    press(8'h29);
    check("restart_state", state, 1);
    check("restart_score", score, 0);
    check("restart_time", time_left, 30);

    for (int i = 0; i < 31; i++) hit_one(h);
    check("score_31", score, 31);
    hit_one(h);
    check("sat_hit_pulse", h, 1);
    check("sat_score", score, 31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
